thumb_fetch_unit: RTL
=====================

// Module: thumb_fetch_unit
// PURPOSE
//  Instruction fetch front end between the CortexM0 decode stage and SRAM port 1 (word-wide, sync read).
//  Issues word fetches and buffers returned words. Splits each word into 16-bit Thumb halfwords,
//  presented in little-endian order with a valid/ready handshake.
//  Handles branch redirects, including halfword-aligned targets, and discards stale in-flight reads.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first halfword after reset; bit 0 ignored
//  BUF_DEPTH   2              word buffer entries; power of two, >= 2
// PORTS
//  CLK         in   1   clock; all state updates on posedge
//  RESET_N     in   1   reset, synchronous, active-low
//  IREQ        out  1   fetch request to SRAM port 1
//  IADDR       out  32  fetch word address; [1:0] always 2'b00
//  INSTR       in   32  SRAM read data; valid the cycle after IREQ/IADDR
//  BR_VALID    in   1   redirect strobe from execute (single-cycle pulse)
//  BR_TARGET   in   32  redirect PC; bit 0 ignored
//  OUT_VALID   out  1   OUT_HW/OUT_PC valid toward decode
//  OUT_READY   in   1   decode accepts halfword
//  OUT_HW      out  16  Thumb halfword
//  OUT_PC      out  32  byte address of OUT_HW; bit 0 always 0
// BEHAVIOUR
//  Reset (RESET_N=0 at posedge) sets IREQ=0 and OUT_VALID=0, empties the buffer, and clears the in-flight flag.
//   Reset also sets fetch_addr={RESET_PC[31:2],2'b00} and hw_sel=RESET_PC[1]. OUT_HW=0 and OUT_PC=RESET_PC.
//   Any INSTR returning after reset is ignored.
//  Fetch: IREQ=1 when (count+inflight)<BUF_DEPTH and BR_VALID=0. IADDR=fetch_addr.
//   Each issued request advances fetch_addr by 4 and sets inflight for one cycle. At most one request is outstanding.
//  Return: INSTR is written to the buffer tail at the posedge after the request, unless that request was killed.
//  Output: head word split into halves. hw_sel=0 selects INSTR[15:0] at PC; hw_sel=1 selects [31:16] at PC+2.
//   OUT_VALID=1 iff buffer not empty. Outputs are driven combinationally from head+hw_sel; no buffer bypass.
//   Transfer = OUT_VALID & OUT_READY. On transfer: hw_sel=0 -> hw_sel=1; hw_sel=1 -> pop, hw_sel=0.
//   OUT_PC advances by 2 on every transfer.
//   While OUT_VALID=1 and no transfer, OUT_HW and OUT_PC hold stable.
//  Redirect (BR_VALID=1 at posedge): a transfer in the same cycle completes first.
//   Then the buffer is flushed and any in-flight request is killed, so its data is dropped next cycle.
//   Then fetch_addr={BR_TARGET[31:2],2'b00}, hw_sel=BR_TARGET[1], and OUT_PC={BR_TARGET[31:1],1'b0}.
//  Latency: BR_VALID in cycle t gives IREQ with the target word in t+1, INSTR in t+2, OUT_VALID=1 in t+3.
//   Reset releases the same way: first IREQ is in the first cycle with RESET_N=1, and OUT_VALID rises two cycles later.
//  Odd-halfword target: the first output is the upper half of the target word. The word pops after that single transfer.
//  Back-to-back BR_VALID: the last strobe wins, and all earlier-target data is dropped.
//  Full: with count=BUF_DEPTH no IREQ is issued; a pop in the same cycle does not enable issue until the next cycle.
//  Simultaneous push and pop in one cycle: count is unchanged, and the FIFO pointers wrap modulo BUF_DEPTH.
//  Sustained rate: one halfword per cycle with OUT_READY=1, no taken branches and BUF_DEPTH>=2.
//  Reset during a transfer or redirect: reset dominates everything.
// STRUCTURE
//  Shared defines (cm0_defs): RESET_PC default, PC width, halfword-select encoding.
//  Sub-module fetch_word_fifo: sync FIFO (BUF_DEPTH x 32), with push/pop/flush/count.
//   FIFO flush takes priority over push.
//  Top: fetch_addr register, inflight/kill flag, hw_sel, PC register, issue logic.
// TESTING
//  1 Reset, RESET_PC=0, mem[0]=32'h2001_2000, mem[4]=32'h4601_2302, OUT_READY=1
//    -> IREQ in the first post-reset cycle, OUT_VALID two cycles later.
//    -> Outputs 2000@0, 2001@2, 2302@4, 4601@6 on consecutive cycles.
//  2 Backpressure: OUT_READY=0 for 5 cycles mid-stream -> OUT_HW/OUT_PC held.
//    -> IREQ drops once count+inflight=2; after release the stream resumes with no loss or duplicate.
//  3 BR_VALID, BR_TARGET=32'h106 in cycle t, mem[0x104]=32'hBEEF_1111 -> IADDR=0x104 at t+1.
//    -> At t+3: OUT_HW=16'hBEEF, OUT_PC=0x106. Next output has OUT_PC=0x108.
//  4 Redirect with a request in flight -> the stale INSTR returned at t+1 never appears on OUT_HW, and the buffer is empty at t+1.
//  5 BR_VALID in cycles t and t+1 (0x200 then 0x300) -> no output from 0x200. First output is OUT_PC=0x300 at t+4.
//  6 RESET_N=0 for one cycle mid-stream with a request in flight
//    -> IREQ=0 and OUT_VALID=0 the next cycle; the restart fetches from RESET_PC.

Source files
------------

// File: rtl/thumb_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// thumb_fetch_unit_pkg
//   Shared CortexM0 fetch definitions: PC width, default reset PC,
//   the halfword-select encoding and a helper that picks one Thumb
//   halfword out of a little-endian instruction word.
// ---------------------------------------------------------------------------
package thumb_fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Which half of the head word is presented next.
  typedef enum logic {
    HW_LO = 1'b0,  // bits [15:0], at the word address
    HW_HI = 1'b1   // bits [31:16], at the word address + 2
  } hw_sel_e;

  function automatic logic [15:0] select_hw(input logic [31:0] word, input hw_sel_e sel);
    return (sel == HW_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/thumb_fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// thumb_fetch_unit_fifo
//   Synchronous word FIFO holding fetched instruction words.
//   Flush takes priority over push and pop. Pointers wrap modulo DEPTH
//   (DEPTH must be a power of two, >= 2).
// Ports
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   push_i, data_i   write data_i at the tail (caller guarantees not full)
//   pop_i            drop the head word (caller guarantees not empty)
//   flush_i          empty the FIFO
//   data_o           head word
//   count_o          number of stored words
//   empty_o          count_o == 0
// ---------------------------------------------------------------------------
module thumb_fetch_unit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only words below count_q are ever presented.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/thumb_fetch_unit.sv
// ---------------------------------------------------------------------------
// thumb_fetch_unit
//   Instruction fetch front end between the CortexM0 decode stage and
//   SRAM port 1 (word wide, one-cycle synchronous read). Issues word
//   fetches, buffers returned words and hands 16-bit Thumb halfwords to
//   decode in little-endian order. Branch redirects flush the buffer and
//   drop any read still in flight.
// Ports
//   CLK, RESET_N          clock, synchronous active-low reset
//   IREQ, IADDR           fetch request / word address ([1:0] = 0)
//   INSTR                 read data, valid the cycle after IREQ
//   BR_VALID, BR_TARGET   redirect strobe and target PC (bit 0 ignored)
//   OUT_VALID, OUT_READY  halfword handshake toward decode
//   OUT_HW, OUT_PC        halfword and its byte address
// Handshake: a halfword moves when OUT_VALID & OUT_READY at a posedge;
//   while OUT_VALID is high and no transfer happens, OUT_HW/OUT_PC hold.
// ---------------------------------------------------------------------------
module thumb_fetch_unit
  import thumb_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IREQ,
  output logic [31:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        BR_VALID,
  input  logic [31:0] BR_TARGET,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_HW,
  output logic [31:0] OUT_PC
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(BUF_DEPTH);

  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   pc_q, pc_d;
  hw_sel_e       hw_sel_q, hw_sel_d;
  logic          inflight_q, inflight_d;

  logic [31:0]   head_word;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW:0]   occupancy;
  logic          xfer;
  logic          pop;
  logic          unused_br_bit0;

  assign unused_br_bit0 = BR_TARGET[0];

  thumb_fetch_unit_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .push_i  (inflight_q),   // read data arrives exactly one cycle after issue
    .pop_i   (pop),
    .flush_i (BR_VALID),     // drops the word arriving this cycle as well
    .data_i  (INSTR),
    .data_o  (head_word),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // Count the read in flight so its return always has a free slot.
    occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    // Gating by RESET_N keeps both sides quiet while reset is held.
    IREQ      = RESET_N && !BR_VALID && (occupancy < DEPTH_V);
    IADDR     = fetch_addr_q;
    OUT_VALID = RESET_N && !fifo_empty;
    OUT_HW    = OUT_VALID ? select_hw(head_word, hw_sel_q) : 16'h0000;
    OUT_PC    = pc_q;
    xfer      = OUT_VALID && OUT_READY;
    pop       = xfer && (hw_sel_q == HW_HI);

    fetch_addr_d = fetch_addr_q;
    inflight_d   = IREQ;
    hw_sel_d     = hw_sel_q;
    pc_d         = pc_q;

    if (IREQ) fetch_addr_d = fetch_addr_q + 32'd4;
    if (xfer) begin
      hw_sel_d = (hw_sel_q == HW_LO) ? HW_HI : HW_LO;
      pc_d     = pc_q + 32'd2;
    end
    // A redirect lands after any same-cycle transfer and overrides it.
    if (BR_VALID) begin
      fetch_addr_d = {BR_TARGET[31:2], 2'b00};
      hw_sel_d     = hw_sel_e'(BR_TARGET[1]);
      pc_d         = {BR_TARGET[31:1], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      hw_sel_q     <= hw_sel_e'(RESET_PC[1]);
      pc_q         <= {RESET_PC[31:1], 1'b0};
      inflight_q   <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      hw_sel_q     <= hw_sel_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule
